// File: rtl/fsmd_seq_arith_if.sv
// Handshake and result bundle for the fsmd_seq_arith multi-cycle arithmetic unit.
interface fsmd_seq_arith_if #(
    parameter int unsigned DATA_W = 16
);
    logic              start_in;
    logic              mode_in;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              ready_out;
    logic              done_out;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              z_out;
    logic              n_out;
    logic              dz_out;

    modport master (
        output start_in, mode_in, a_in, b_in,
        input  ready_out, done_out, hi_out, lo_out, z_out, n_out, dz_out
    );

    modport slave (
        input  start_in, mode_in, a_in, b_in,
        output ready_out, done_out, hi_out, lo_out, z_out, n_out, dz_out
    );
endinterface

// File: rtl/fsmd_seq_arith.sv
// Sequential shift-add multiplier / restoring divider, one iteration per cycle.
// Define FSMD_SIGNED_EN for two's-complement operands (sign-magnitude wrapping).
module fsmd_seq_arith #(
    parameter int unsigned DATA_W = 16
) (
    input logic             clk,
    input logic             srst,
    fsmd_seq_arith_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StMul  = 3'd2;
    localparam logic [2:0] StDiv  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    logic [2:0]          state_q;
    logic                mode_q;
    logic [DATA_W-1:0]   a_q, b_q, acc_q, mq_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                z_q, n_q, dz_q;

    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum, sh_rem;
    logic                borrow;
    logic [DATA_W-1:0]   it_acc, it_mq;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem;
    logic [DATA_W-1:0]   res_hi, res_lo;

`ifdef FSMD_SIGNED_EN
    logic sa_q, sb_q;
    assign a_mag = a_q[DATA_W-1] ? (~a_q + 1'b1) : a_q;
    assign b_mag = b_q[DATA_W-1] ? (~b_q + 1'b1) : b_q;
`else
    assign a_mag = a_q;
    assign b_mag = b_q;
`endif

    // mq_q holds the multiplier (MUL) or the dividend/quotient (DIV).
    always_comb begin
        mul_sum = {1'b0, acc_q} + ({(DATA_W+1){mq_q[0]}} & {1'b0, a_q});
        sh_rem  = {acc_q, mq_q[DATA_W-1]};
        borrow  = sh_rem < {1'b0, b_q};
        if (mode_q) begin
            it_acc = borrow ? sh_rem[DATA_W-1:0] : (sh_rem[DATA_W-1:0] - b_q);
            it_mq  = {mq_q[DATA_W-2:0], ~borrow};
        end else begin
            it_acc = mul_sum[DATA_W:1];
            it_mq  = {mul_sum[0], mq_q[DATA_W-1:1]};
        end
    end

    always_comb begin
        prod = {it_acc, it_mq};
        quo  = it_mq;
        rem  = it_acc;
`ifdef FSMD_SIGNED_EN
        if (sa_q ^ sb_q) begin
            prod = ~prod + 1'b1;
            quo  = ~quo + 1'b1;
        end
        if (sa_q) begin
            rem = ~rem + 1'b1;
        end
`endif
        res_hi = mode_q ? rem : prod[2*DATA_W-1:DATA_W];
        res_lo = mode_q ? quo : prod[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            dz_q    <= 1'b0;
`ifdef FSMD_SIGNED_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start_in) begin
                        a_q     <= bus.a_in;
                        b_q     <= bus.b_in;
                        mode_q  <= bus.mode_in;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    acc_q <= '0;
                    cnt_q <= CNT_W'(DATA_W);
                    mq_q  <= mode_q ? a_mag : b_mag;
                    a_q   <= a_mag;
                    b_q   <= b_mag;
`ifdef FSMD_SIGNED_EN
                    sa_q  <= a_q[DATA_W-1];
                    sb_q  <= b_q[DATA_W-1];
`endif
                    if (!mode_q) begin
                        state_q <= StMul;
                    end else if (b_q == '0) begin
                        // a_q is still the raw operand here, so hi reports a unchanged.
                        hi_q    <= a_q;
                        lo_q    <= '1;
                        z_q     <= 1'b0;
                        n_q     <= 1'b1;
                        dz_q    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StDiv;
                    end
                end
                StMul, StDiv: begin
                    acc_q <= it_acc;
                    mq_q  <= it_mq;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                        z_q     <= mode_q ? (res_lo == '0) : ({res_hi, res_lo} == '0);
                        n_q     <= mode_q ? res_lo[DATA_W-1] : res_hi[DATA_W-1];
                        dz_q    <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready_out = (state_q == StIdle);
    assign bus.done_out  = (state_q == StDone);
    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;
    assign bus.z_out     = z_q;
    assign bus.n_out     = n_q;
    assign bus.dz_out    = dz_q;
endmodule

// File: tb/tb_fsmd_seq_arith.sv
// Scoreboard bench for fsmd_seq_arith: driver pushes model results, monitor checks on done_out.
module tb_fsmd_seq_arith;
    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         z;
        logic         n;
        logic         dz;
        int           done_cyc;
    } exp_t;

    logic clk;
    logic srst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    fsmd_seq_arith_if #(.DATA_W(W)) bus ();

    fsmd_seq_arith #(.DATA_W(W)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    function automatic exp_t model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint p;
        longint q;
        longint r;
        logic [2*W-1:0] pw;
        e.dz = 1'b0;
        if (!m) begin
`ifdef FSMD_SIGNED_EN
            p = longint'($signed(a)) * longint'($signed(b));
`else
            p = longint'(a) * longint'(b);
`endif
            pw   = p[2*W-1:0];
            e.hi = pw[2*W-1:W];
            e.lo = pw[W-1:0];
            e.z  = (pw == '0);
            e.n  = e.hi[W-1];
        end else if (b == '0) begin
            e.hi = a;
            e.lo = '1;
            e.z  = 1'b0;
            e.n  = 1'b1;
            e.dz = 1'b1;
        end else begin
`ifdef FSMD_SIGNED_EN
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
`else
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
`endif
            e.lo = q[W-1:0];
            e.hi = r[W-1:0];
            e.z  = (e.lo == '0);
            e.n  = e.lo[W-1];
        end
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic issue(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit track);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!bus.ready_out && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.ready_out) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready_out stayed 0 for %0d cycles, expected 1", t);
            return;
        end
        bus.mode_in  = m;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.start_in = 1'b1;
        if (track) begin
            e = model(m, a, b);
            e.done_cyc = cyc + 1 + ((m && b == '0) ? 1 : (W + 1));
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.start_in = 1'b0;
    endtask

    // Monitor
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!srst && bus.done_out) begin
                check("done_single_pulse", longint'(prev), 0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done_out=1 at cycle %0d, expected no result", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("latency", cyc, e.done_cyc);
                    check("hi", bus.hi_out, e.hi);
                    check("lo", bus.lo_out, e.lo);
                    check("z", bus.z_out, e.z);
                    check("n", bus.n_out, e.n);
                    check("dz", bus.dz_out, e.dz);
                end
            end
            prev = !srst && bus.done_out;
        end
    end

    initial begin
        int t;
        logic m;
        logic [W-1:0] ra, rb;
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        srst         = 1'b1;
        bus.start_in = 1'b0;
        bus.mode_in  = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready_out, 1);
        check("rst_done", bus.done_out, 0);
        check("rst_hi", bus.hi_out, 0);
        check("rst_lo", bus.lo_out, 0);
        check("rst_flags", {bus.z_out, bus.n_out, bus.dz_out}, 0);
        srst = 1'b0;

        issue(1'b0, 16'd300, 16'd200, 1'b1);
        issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        issue(1'b0, 16'd0, 16'd1234, 1'b1);
        issue(1'b1, 16'd1000, 16'd7, 1'b1);
        issue(1'b1, 16'd5, 16'd0, 1'b1);
        issue(1'b0, 16'd9, 16'd9, 1'b1);
        issue(1'b1, 16'hFFFF, 16'd1, 1'b1);
`ifdef FSMD_SIGNED_EN
        issue(1'b1, 16'hFFF9, 16'd2, 1'b1);
        issue(1'b0, 16'hFFFD, 16'd5, 1'b1);
        issue(1'b1, 16'h8000, 16'hFFFF, 1'b1);
        issue(1'b1, 16'h8000, 16'd0, 1'b1);
`endif

        // start_in pulses while busy must not disturb the running divide.
        issue(1'b1, 16'd1000, 16'd7, 1'b1);
        repeat (2) @(negedge clk);
        bus.mode_in = 1'b0; bus.a_in = 16'd3; bus.b_in = 16'd3; bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (5) @(negedge clk);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;

        // Asynchronous reset in the middle of a divide.
        issue(1'b1, 16'd1000, 16'd7, 1'b0);
        repeat (9) @(negedge clk);
        #2 srst = 1'b1;
        #1;
        check("midrst_ready", bus.ready_out, 1);
        check("midrst_done", bus.done_out, 0);
        check("midrst_hi", bus.hi_out, 0);
        check("midrst_lo", bus.lo_out, 0);
        check("midrst_flags", {bus.z_out, bus.n_out, bus.dz_out}, 0);
        @(negedge clk);
        srst = 1'b0;
        repeat (25) @(negedge clk);
        check("post_rst_ready", bus.ready_out, 1);

        for (int i = 0; i < 40; i++) begin
            m  = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 :
                 ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
            issue(m, ra, rb, 1'b1);
        end

        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
